// File: rtl/frame_capture_writer.sv
// Write side of the rotated-scan frame buffer: captures one raster-order frame and holds it for the reader.
// Optional ping-pong banking is enabled with FRAME_CAPTURE_DOUBLE_BUF_EN.
module frame_capture_writer #(
    parameter int unsigned PIX_W    = 1,
    parameter int unsigned DIM_LOG2 = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  pix_valid,
    input  logic                  pix_sof,
    input  logic [PIX_W-1:0]      pix_data,
    output logic                  pix_ready,
    output logic                  frame_ready,
    input  logic                  frame_release,
    input  logic                  rd_en,
    input  logic [2*DIM_LOG2-1:0] rd_addr,
    output logic [PIX_W-1:0]      rd_data,
    output logic [2*DIM_LOG2:0]   wr_count,
    output logic                  err_sof
);

    localparam int unsigned ADDR_W = 2 * DIM_LOG2;
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned NPIX   = 1 << ADDR_W;
`ifdef FRAME_CAPTURE_DOUBLE_BUF_EN
    localparam int unsigned MEM_AW = ADDR_W + 1;
`else
    localparam int unsigned MEM_AW = ADDR_W;
`endif
    localparam int unsigned MEM_DEPTH = 1 << MEM_AW;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FULL    = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [CNT_W-1:0]    wr_count_q, wr_count_d;
    logic                frame_ready_q, frame_ready_d;
    logic                err_sof_q, err_sof_d;
    logic                pix_ready_q, pix_ready_d;
    logic [PIX_W-1:0]    rd_data_q;
`ifdef FRAME_CAPTURE_DOUBLE_BUF_EN
    logic                wr_bank_q, wr_bank_d;
`endif

    logic                accept_c;
    logic                wr_en_c;
    logic [ADDR_W-1:0]   wr_off_c;
    logic [MEM_AW-1:0]   wr_idx_c;
    logic [MEM_AW-1:0]   rd_idx_c;

    logic [PIX_W-1:0]    mem [MEM_DEPTH];

    // Capture control: clear overrides everything, then per-state accept/complete/release handling.
    always_comb begin
        state_d       = state_q;
        wr_addr_d     = wr_addr_q;
        wr_count_d    = wr_count_q;
        frame_ready_d = frame_ready_q;
        err_sof_d     = err_sof_q;
`ifdef FRAME_CAPTURE_DOUBLE_BUF_EN
        wr_bank_d     = wr_bank_q;
`endif
        wr_en_c       = 1'b0;
        wr_off_c      = wr_addr_q;
        accept_c      = pix_valid & pix_ready_q;

        if (clear) begin
            state_d       = ST_IDLE;
            wr_addr_d     = '0;
            wr_count_d    = '0;
            frame_ready_d = 1'b0;
            err_sof_d     = 1'b0;
        end else begin
`ifdef FRAME_CAPTURE_DOUBLE_BUF_EN
            // Reader hand-back outside FULL only frees the read bank.
            if (frame_release && (state_q != ST_FULL)) begin
                frame_ready_d = 1'b0;
            end
`endif
            case (state_q)
                ST_IDLE: begin
                    if (accept_c && pix_sof) begin
                        wr_en_c    = 1'b1;
                        wr_off_c   = '0;
                        wr_addr_d  = ADDR_W'(1);
                        wr_count_d = CNT_W'(1);
                        state_d    = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (accept_c) begin
                        wr_en_c = 1'b1;
                        if (pix_sof) begin
                            wr_off_c   = '0;
                            wr_addr_d  = ADDR_W'(1);
                            wr_count_d = CNT_W'(1);
                            err_sof_d  = 1'b1;
                        end else begin
                            wr_addr_d  = wr_addr_q + ADDR_W'(1);
                            wr_count_d = wr_count_q + CNT_W'(1);
                            if (wr_addr_q == ADDR_W'(NPIX - 1)) begin
`ifdef FRAME_CAPTURE_DOUBLE_BUF_EN
                                if (frame_ready_d) begin
                                    state_d = ST_FULL;
                                end else begin
                                    wr_bank_d     = ~wr_bank_q;
                                    frame_ready_d = 1'b1;
                                    wr_count_d    = '0;
                                    state_d       = ST_IDLE;
                                end
`else
                                frame_ready_d = 1'b1;
                                state_d       = ST_FULL;
`endif
                            end
                        end
                    end
                end
                ST_FULL: begin
                    if (frame_release) begin
                        wr_count_d = '0;
                        state_d    = ST_IDLE;
`ifdef FRAME_CAPTURE_DOUBLE_BUF_EN
                        // Parked frame becomes readable immediately.
                        wr_bank_d     = ~wr_bank_q;
                        frame_ready_d = 1'b1;
`else
                        frame_ready_d = 1'b0;
`endif
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        pix_ready_d = (state_d != ST_FULL);
    end

    // Memory indices: in ping-pong mode the reader always sees the bank not being written.
    always_comb begin
`ifdef FRAME_CAPTURE_DOUBLE_BUF_EN
        wr_idx_c = {wr_bank_q, wr_off_c};
        rd_idx_c = {~wr_bank_q, rd_addr};
`else
        wr_idx_c = wr_off_c;
        rd_idx_c = rd_addr;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            wr_addr_q     <= '0;
            wr_count_q    <= '0;
            frame_ready_q <= 1'b0;
            err_sof_q     <= 1'b0;
            pix_ready_q   <= 1'b1;
`ifdef FRAME_CAPTURE_DOUBLE_BUF_EN
            wr_bank_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            wr_addr_q     <= wr_addr_d;
            wr_count_q    <= wr_count_d;
            frame_ready_q <= frame_ready_d;
            err_sof_q     <= err_sof_d;
            pix_ready_q   <= pix_ready_d;
`ifdef FRAME_CAPTURE_DOUBLE_BUF_EN
            wr_bank_q     <= wr_bank_d;
`endif
        end
    end

    // Pixel storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_idx_c] <= pix_data;
        end
    end

    // Registered read; a same-cycle write to the same location returns the old value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_idx_c];
        end
    end

    assign pix_ready   = pix_ready_q;
    assign frame_ready = frame_ready_q;
    assign wr_count    = wr_count_q;
    assign err_sof     = err_sof_q;
    assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_frame_capture_writer.sv
// Self-checking bench for frame_capture_writer; read data is checked through a scoreboard queue.
module tb_frame_capture_writer;

    localparam int NPIX = 1024;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clear;
    logic        pix_valid;
    logic        pix_sof;
    logic        pix_data;
    logic        pix_ready;
    logic        frame_ready;
    logic        frame_release;
    logic        rd_en;
    logic [9:0]  rd_addr;
    logic        rd_data;
    logic [10:0] wr_count;
    logic        err_sof;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic model [NPIX];
    logic exp_q [$];
    logic exp_v;

    frame_capture_writer #(.PIX_W(1), .DIM_LOG2(5)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .clear         (clear),
        .pix_valid     (pix_valid),
        .pix_sof       (pix_sof),
        .pix_data      (pix_data),
        .pix_ready     (pix_ready),
        .frame_ready   (frame_ready),
        .frame_release (frame_release),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .wr_count      (wr_count),
        .err_sof       (err_sof)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pix(input logic sof, input logic d);
        pix_valid = 1'b1;
        pix_sof   = sof;
        pix_data  = d;
        tick();
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic issue_read(input int addr);
        exp_q.push_back(model[addr]);
        rd_en   = 1'b1;
        rd_addr = 10'(addr);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic release_frame();
        frame_release = 1'b1;
        tick();
        frame_release = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; clear = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0; pix_data = 1'b0;
        frame_release = 1'b0; rd_en = 1'b0; rd_addr = '0;
        repeat (3) tick();
        n_checks++; if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL reset_pix_ready got %0d want 1", pix_ready); end
        n_checks++; if (frame_ready !== 1'b0) begin n_fail++; $display("FAIL reset_frame_ready got %0d want 0", frame_ready); end
        n_checks++; if (wr_count !== 11'd0) begin n_fail++; $display("FAIL reset_wr_count got %0d want 0", wr_count); end
        n_checks++; if (err_sof !== 1'b0) begin n_fail++; $display("FAIL reset_err_sof got %0d want 0", err_sof); end
        n_checks++; if (rd_data !== 1'b0) begin n_fail++; $display("FAIL reset_rd_data got %0d want 0", rd_data); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_raster();
        int rd_list [7] = '{992, 993, 0, 1, 31, 32, 1023};
        for (int i = 0; i < NPIX; i++) begin
            model[i] = 1'(i & 1);
            send_pix(i == 0, model[i]);
            if (i == NPIX - 2) begin
                n_checks++; if (frame_ready !== 1'b0) begin n_fail++; $display("FAIL raster_early_ready got %0d want 0", frame_ready); end
            end
        end
        n_checks++; if (frame_ready !== 1'b1) begin n_fail++; $display("FAIL raster_frame_ready got %0d want 1", frame_ready); end
        n_checks++; if (wr_count !== 11'd1024) begin n_fail++; $display("FAIL raster_wr_count got %0d want 1024", wr_count); end
        n_checks++; if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL raster_pix_ready got %0d want 0", pix_ready); end
        n_checks++; if (err_sof !== 1'b0) begin n_fail++; $display("FAIL raster_err_sof got %0d want 0", err_sof); end
        foreach (rd_list[k]) begin
            issue_read(rd_list[k]);
            exp_v = exp_q.pop_front();
            n_checks++; if (rd_data !== exp_v) begin n_fail++; $display("FAIL raster_read addr %0d got %0d want %0d", rd_list[k], rd_data, exp_v); end
        end
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 20; k++) begin
            pix_valid = 1'b1; pix_sof = 1'(k & 1); pix_data = ~model[0];
            tick();
            n_checks++; if (wr_count !== 11'd1024 || frame_ready !== 1'b1) begin
                n_fail++; $display("FAIL bp_hold cycle %0d got count %0d ready %0d want 1024 1", k, wr_count, frame_ready); end
        end
        frame_release = 1'b1; pix_valid = 1'b1; pix_sof = 1'b1; pix_data = ~model[0];
        tick();
        frame_release = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0;
        n_checks++; if (frame_ready !== 1'b0) begin n_fail++; $display("FAIL bp_release_ready got %0d want 0", frame_ready); end
        n_checks++; if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_pix_ready got %0d want 1", pix_ready); end
        n_checks++; if (wr_count !== 11'd0) begin n_fail++; $display("FAIL bp_release_count got %0d want 0", wr_count); end
        issue_read(0);
        exp_v = exp_q.pop_front();
        n_checks++; if (rd_data !== exp_v) begin n_fail++; $display("FAIL bp_no_write got %0d want %0d", rd_data, exp_v); end
    endtask

    task automatic test_pre_sof();
        for (int i = 0; i < 10; i++) send_pix(1'b0, ~model[i]);
        n_checks++; if (wr_count !== 11'd0) begin n_fail++; $display("FAIL presof_count got %0d want 0", wr_count); end
        for (int i = 0; i < 10; i++) begin
            issue_read(i);
            exp_v = exp_q.pop_front();
            n_checks++; if (rd_data !== exp_v) begin n_fail++; $display("FAIL presof_mem addr %0d got %0d want %0d", i, rd_data, exp_v); end
        end
        for (int i = 0; i < NPIX; i++) begin
            model[i] = 1'((i >> 1) & 1);
            send_pix(i == 0, model[i]);
        end
        n_checks++; if (frame_ready !== 1'b1 || wr_count !== 11'd1024) begin
            n_fail++; $display("FAIL presof_frame got ready %0d count %0d want 1 1024", frame_ready, wr_count); end
        for (int i = 0; i < 4; i++) begin
            issue_read(i + 1020);
            exp_v = exp_q.pop_front();
            n_checks++; if (rd_data !== exp_v) begin n_fail++; $display("FAIL presof_read addr %0d got %0d want %0d", i + 1020, rd_data, exp_v); end
        end
        release_frame();
        n_checks++; if (frame_ready !== 1'b0) begin n_fail++; $display("FAIL presof_release got %0d want 0", frame_ready); end
    endtask

    task automatic test_mid_sof();
        logic d;
        int   a;
        for (int i = 0; i < 500; i++) begin
            d = 1'($urandom); model[i] = d; send_pix(i == 0, d);
        end
        d = 1'($urandom); model[0] = d; send_pix(1'b1, d);
        n_checks++; if (err_sof !== 1'b1) begin n_fail++; $display("FAIL midsof_err got %0d want 1", err_sof); end
        n_checks++; if (wr_count !== 11'd1) begin n_fail++; $display("FAIL midsof_count got %0d want 1", wr_count); end
        for (int i = 1; i < NPIX - 1; i++) begin
            d = 1'($urandom); model[i] = d; send_pix(1'b0, d);
        end
        n_checks++; if (frame_ready !== 1'b0 || wr_count !== 11'd1023) begin
            n_fail++; $display("FAIL midsof_early got ready %0d count %0d want 0 1023", frame_ready, wr_count); end
        d = 1'($urandom); model[NPIX-1] = d; send_pix(1'b0, d);
        n_checks++; if (frame_ready !== 1'b1 || wr_count !== 11'd1024) begin
            n_fail++; $display("FAIL midsof_done got ready %0d count %0d want 1 1024", frame_ready, wr_count); end
        for (int k = 0; k < 8; k++) begin
            a = int'($urandom_range(1023, 0));
            issue_read(a);
            exp_v = exp_q.pop_front();
            n_checks++; if (rd_data !== exp_v) begin n_fail++; $display("FAIL midsof_read addr %0d got %0d want %0d", a, rd_data, exp_v); end
        end
        release_frame();
        n_checks++; if (err_sof !== 1'b1) begin n_fail++; $display("FAIL midsof_sticky got %0d want 1", err_sof); end
    endtask

    task automatic test_clear();
        logic d;
        for (int i = 0; i < 300; i++) begin
            d = 1'($urandom); model[i] = d; send_pix(i == 0, d);
        end
        n_checks++; if (wr_count !== 11'd300) begin n_fail++; $display("FAIL clear_pre_count got %0d want 300", wr_count); end
        clear = 1'b1; pix_valid = 1'b1; pix_sof = 1'b1; pix_data = ~model[0];
        tick();
        clear = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0;
        n_checks++; if (wr_count !== 11'd0) begin n_fail++; $display("FAIL clear_count got %0d want 0", wr_count); end
        n_checks++; if (err_sof !== 1'b0) begin n_fail++; $display("FAIL clear_err got %0d want 0", err_sof); end
        n_checks++; if (frame_ready !== 1'b0 || pix_ready !== 1'b1) begin
            n_fail++; $display("FAIL clear_flags got ready %0d pix_ready %0d want 0 1", frame_ready, pix_ready); end
        send_pix(1'b0, ~model[1]);
        n_checks++; if (wr_count !== 11'd0) begin n_fail++; $display("FAIL clear_idle got %0d want 0", wr_count); end
        for (int i = 0; i < 2; i++) begin
            issue_read(i);
            exp_v = exp_q.pop_front();
            n_checks++; if (rd_data !== exp_v) begin n_fail++; $display("FAIL clear_mem addr %0d got %0d want %0d", i, rd_data, exp_v); end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 700; i++) begin
            model[(i < 100) ? i : i - 100] = 1'b1;
            send_pix((i == 0) || (i == 100), 1'b1);
        end
        n_checks++; if (err_sof !== 1'b1 || wr_count !== 11'd600) begin
            n_fail++; $display("FAIL areset_pre got err %0d count %0d want 1 600", err_sof, wr_count); end
        issue_read(5);
        exp_v = exp_q.pop_front();
        n_checks++; if (rd_data !== exp_v) begin n_fail++; $display("FAIL areset_pre_read got %0d want %0d", rd_data, exp_v); end
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (rd_data !== 1'b0) begin n_fail++; $display("FAIL areset_rd_data got %0d want 0", rd_data); end
        n_checks++; if (wr_count !== 11'd0) begin n_fail++; $display("FAIL areset_count got %0d want 0", wr_count); end
        n_checks++; if (err_sof !== 1'b0 || frame_ready !== 1'b0 || pix_ready !== 1'b1) begin
            n_fail++; $display("FAIL areset_flags got err %0d ready %0d pix_ready %0d want 0 0 1", err_sof, frame_ready, pix_ready); end
        tick();
        reset_n = 1'b1;
        tick();
        send_pix(1'b0, 1'b0);
        n_checks++; if (wr_count !== 11'd0) begin n_fail++; $display("FAIL areset_idle got %0d want 0", wr_count); end
        issue_read(5);
        exp_v = exp_q.pop_front();
        n_checks++; if (rd_data !== exp_v) begin n_fail++; $display("FAIL areset_mem_kept got %0d want %0d", rd_data, exp_v); end
    endtask

    task automatic test_double_buf();
        for (int i = 0; i < NPIX; i++) begin
            model[i] = 1'b0;
            send_pix(i == 0, 1'b0);
            if (i == NPIX - 2) begin
                n_checks++; if (frame_ready !== 1'b0) begin n_fail++; $display("FAIL db_early got %0d want 0", frame_ready); end
            end
        end
        n_checks++; if (frame_ready !== 1'b1 || pix_ready !== 1'b1) begin
            n_fail++; $display("FAIL db_frame_a got ready %0d pix_ready %0d want 1 1", frame_ready, pix_ready); end
        issue_read(7);
        exp_v = exp_q.pop_front();
        n_checks++; if (rd_data !== exp_v) begin n_fail++; $display("FAIL db_read_a got %0d want %0d", rd_data, exp_v); end
        for (int i = 0; i < NPIX; i++) send_pix(i == 0, 1'b1);
        n_checks++; if (frame_ready !== 1'b1 || pix_ready !== 1'b0 || wr_count !== 11'd1024) begin
            n_fail++; $display("FAIL db_stall got ready %0d pix_ready %0d count %0d want 1 0 1024", frame_ready, pix_ready, wr_count); end
        issue_read(7);
        exp_v = exp_q.pop_front();
        n_checks++; if (rd_data !== exp_v) begin n_fail++; $display("FAIL db_read_a_kept got %0d want %0d", rd_data, exp_v); end
        release_frame();
        n_checks++; if (frame_ready !== 1'b1 || pix_ready !== 1'b1) begin
            n_fail++; $display("FAIL db_swap got ready %0d pix_ready %0d want 1 1", frame_ready, pix_ready); end
        for (int i = 0; i < NPIX; i++) model[i] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            issue_read(k * 500);
            exp_v = exp_q.pop_front();
            n_checks++; if (rd_data !== exp_v) begin n_fail++; $display("FAIL db_read_b addr %0d got %0d want %0d", k * 500, rd_data, exp_v); end
        end
    endtask

    initial begin
        test_reset();
`ifdef FRAME_CAPTURE_DOUBLE_BUF_EN
        test_double_buf();
`else
        test_raster();
        test_backpressure();
        test_pre_sof();
        test_mid_sof();
        test_clear();
        test_async_reset();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
